// File: rtl/circular_dma_pkg.sv
// Shared definitions for the circular DMA blocks: FSM states, DataMover command/status layout
// and sticky status flag positions.
package circular_dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitData,
    StCmd,
    StSts,
    StError
  } mm2s_state_e;

  // DataMover command word layout
  localparam int unsigned CmdBttLsb   = 0;
  localparam int unsigned CmdBttWidth = 23;
  localparam int unsigned CmdTypeBit  = 23;
  localparam int unsigned CmdDsaLsb   = 24;
  localparam int unsigned CmdDsaWidth = 6;
  localparam int unsigned CmdEofBit   = 30;
  localparam int unsigned CmdDrrBit   = 31;
  localparam int unsigned CmdSaddrLsb = 32;
  localparam int unsigned CmdTagWidth = 4;

  localparam logic TYPE_INCR = 1'b1;

  // DataMover status byte layout
  localparam int unsigned StsTagLsb    = 0;
  localparam int unsigned StsInterrBit = 4;
  localparam int unsigned StsDecerrBit = 5;
  localparam int unsigned StsSlverrBit = 6;
  localparam int unsigned StsOkayBit   = 7;

  // status_flags bit positions, common to the S2MM and MM2S sides
  localparam int unsigned FlagInterr      = 0;
  localparam int unsigned FlagSlverr      = 1;
  localparam int unsigned FlagDecerr      = 2;
  localparam int unsigned FlagTagMismatch = 3;

endpackage

// File: rtl/circular_dma_reader_fsm.sv
// Command/status sequencer for the circular MM2S reader: computes wrap-aware chunks, issues
// DataMover read commands and advances the read offset on good status.
module circular_dma_reader_fsm
  import circular_dma_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH = 32,
  parameter int unsigned C_AXIS_WIDTH = 64,
  parameter int unsigned C_MAX_BURST  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [C_ADDR_WIDTH-1:0] mem_base,
  input  logic [31:0]             mem_size,
  input  logic [31:0]             write_offset,
  output logic [31:0]             read_offset,
  output logic [31:0]             bytes_read,
  output logic [3:0]              status_flags,
  output logic                    irq_set,
  input  logic [7:0]              sts_tdata,
  input  logic                    sts_tvalid,
  output logic                    sts_tready,
  output logic [C_ADDR_WIDTH+39:0] cmd_tdata,
  output logic                    cmd_tvalid,
  input  logic                    cmd_tready
);

  localparam logic [31:0] MaxChunk = 32'(C_MAX_BURST * (C_AXIS_WIDTH / 8));

  mm2s_state_e state_q, state_d;
  logic        enable_q;
  logic [31:0] read_offset_q, bytes_read_q, chunk_q;
  logic [3:0]  flags_q, tag_q;

  logic [31:0] avail, room, chunk_calc, off_sum, off_next;
  logic        start, sts_hs, tag_match, sts_ok;
  logic [3:0]  err_flags;

  always_comb begin
    avail = (write_offset >= read_offset_q) ? write_offset - read_offset_q
                                            : mem_size - read_offset_q + write_offset;
    room       = mem_size - read_offset_q;
    chunk_calc = avail;
    if (chunk_calc > MaxChunk) chunk_calc = MaxChunk;
    if (chunk_calc > room) chunk_calc = room;
  end

  assign start     = (state_q == StIdle) && enable && !enable_q;
  assign sts_hs    = (state_q == StSts) && sts_tvalid;
  assign tag_match = sts_tdata[StsTagLsb +: 4] == tag_q;
  assign sts_ok    = sts_tdata[StsOkayBit] && tag_match;
  assign off_sum   = read_offset_q + chunk_q;
  assign off_next  = (off_sum == mem_size) ? '0 : off_sum;

  always_comb begin
    err_flags                  = '0;
    err_flags[FlagTagMismatch] = !tag_match;
    err_flags[FlagDecerr]      = sts_tdata[StsDecerrBit];
    err_flags[FlagSlverr]      = sts_tdata[StsSlverrBit];
    err_flags[FlagInterr]      = sts_tdata[StsInterrBit];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Once a command is presented it always runs to its status before honouring !enable.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (start) state_d = StWaitData;
      StWaitData: begin
        if (!enable)          state_d = StIdle;
        else if (avail != '0) state_d = StCmd;
      end
      StCmd:      if (cmd_tready) state_d = StSts;
      StSts: begin
        if (sts_tvalid) begin
          if (!sts_ok)      state_d = StError;
          else if (enable)  state_d = StWaitData;
          else              state_d = StIdle;
        end
      end
      StError:    if (!enable) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q      <= 1'b0;
      read_offset_q <= '0;
      bytes_read_q  <= '0;
      chunk_q       <= '0;
      flags_q       <= '0;
      tag_q         <= '0;
    end else begin
      enable_q <= enable;
      if (start) begin
        read_offset_q <= '0;
        bytes_read_q  <= '0;
        flags_q       <= '0;
      end
      if (state_q == StWaitData && enable && avail != '0) chunk_q <= chunk_calc;
      if (sts_hs) begin
        if (sts_ok) begin
          read_offset_q <= off_next;
          bytes_read_q  <= bytes_read_q + chunk_q;
          tag_q         <= tag_q + 4'd1;
        end else begin
          flags_q <= flags_q | err_flags;
        end
      end
    end
  end

  always_comb begin
    cmd_tdata                                = '0;
    cmd_tdata[CmdBttLsb +: CmdBttWidth]      = chunk_q[CmdBttWidth-1:0];
    cmd_tdata[CmdTypeBit]                    = TYPE_INCR;
    cmd_tdata[CmdDsaLsb +: CmdDsaWidth]      = '0;
    cmd_tdata[CmdEofBit]                     = 1'b1;
    cmd_tdata[CmdDrrBit]                     = 1'b0;
    cmd_tdata[CmdSaddrLsb +: C_ADDR_WIDTH]   = mem_base + C_ADDR_WIDTH'(read_offset_q);
    cmd_tdata[CmdSaddrLsb + C_ADDR_WIDTH +: CmdTagWidth] = tag_q;
    cmd_tvalid = (state_q == StCmd);
    sts_tready = (state_q == StSts);
    // Drained means the offset after this completion has caught up with the producer.
    irq_set    = sts_hs && (!sts_ok || off_next == write_offset);
  end

  assign read_offset  = read_offset_q;
  assign bytes_read   = bytes_read_q;
  assign status_flags = flags_q;

endmodule

// File: rtl/circular_dma_reader.sv
// Circular-buffer MM2S reader: streams DataMover read data straight through to the consumer
// and raises a level interrupt when the buffer drains or a read fails.
module circular_dma_reader
  import circular_dma_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH = 32,
  parameter int unsigned C_AXIS_WIDTH = 64,
  parameter int unsigned C_MAX_BURST  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear_irq,
  output logic                     irq,
  output logic [3:0]               status_flags,
  input  logic [C_ADDR_WIDTH-1:0]  mem_base,
  input  logic [31:0]              mem_size,
  input  logic [31:0]              write_offset,
  output logic [31:0]              read_offset,
  output logic [31:0]              bytes_read,
  input  logic [C_AXIS_WIDTH-1:0]  s_axis_mm2s_tdata,
  input  logic                     s_axis_mm2s_tlast,
  input  logic                     s_axis_mm2s_tvalid,
  output logic                     s_axis_mm2s_tready,
  input  logic [7:0]               s_axis_mm2s_sts_tdata,
  input  logic                     s_axis_mm2s_sts_tkeep,
  input  logic                     s_axis_mm2s_sts_tlast,
  input  logic                     s_axis_mm2s_sts_tvalid,
  output logic                     s_axis_mm2s_sts_tready,
  output logic [C_AXIS_WIDTH-1:0]  m_axis_mm2s_tdata,
  output logic                     m_axis_mm2s_tlast,
  output logic                     m_axis_mm2s_tvalid,
  input  logic                     m_axis_mm2s_tready,
  output logic [C_ADDR_WIDTH+39:0] m_axis_mm2s_cmd_tdata,
  output logic                     m_axis_mm2s_cmd_tvalid,
  input  logic                     m_axis_mm2s_cmd_tready
);

  logic irq_set, irq_q;
  logic unused_sts;

  // Status is a single-beat packet; keep/last carry no extra information.
  assign unused_sts = ^{s_axis_mm2s_sts_tkeep, s_axis_mm2s_sts_tlast};

  assign m_axis_mm2s_tdata  = s_axis_mm2s_tdata;
  assign m_axis_mm2s_tlast  = s_axis_mm2s_tlast;
  assign m_axis_mm2s_tvalid = s_axis_mm2s_tvalid;
  assign s_axis_mm2s_tready = m_axis_mm2s_tready;

  circular_dma_reader_fsm #(
    .C_ADDR_WIDTH (C_ADDR_WIDTH),
    .C_AXIS_WIDTH (C_AXIS_WIDTH),
    .C_MAX_BURST  (C_MAX_BURST)
  ) u_fsm (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .mem_base     (mem_base),
    .mem_size     (mem_size),
    .write_offset (write_offset),
    .read_offset  (read_offset),
    .bytes_read   (bytes_read),
    .status_flags (status_flags),
    .irq_set      (irq_set),
    .sts_tdata    (s_axis_mm2s_sts_tdata),
    .sts_tvalid   (s_axis_mm2s_sts_tvalid),
    .sts_tready   (s_axis_mm2s_sts_tready),
    .cmd_tdata    (m_axis_mm2s_cmd_tdata),
    .cmd_tvalid   (m_axis_mm2s_cmd_tvalid),
    .cmd_tready   (m_axis_mm2s_cmd_tready)
  );

  // A set in the same cycle as clear_irq takes priority.
  always_ff @(posedge clk) begin
    if (rst)            irq_q <= 1'b0;
    else if (irq_set)   irq_q <= 1'b1;
    else if (clear_irq) irq_q <= 1'b0;
  end

  assign irq = irq_q;

endmodule
